// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared opcodes, select encodings and FSM states for the multi-cycle control path
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_A_PC    = 2'b00,
    SRC_A_OLDPC = 2'b01,
    SRC_A_RS1   = 2'b10
  } src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_IMM  = 2'b01,
    SRC_B_FOUR = 2'b10
  } src_b_t;

  typedef enum logic [1:0] {
    RES_ALUOUT  = 2'b00,
    RES_MEMDATA = 2'b01,
    RES_ALU     = 2'b10
  } result_src_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALU_WB  = 4'd8,
    S_BEQ     = 4'd9,
    S_TRAP    = 4'd10
  } state_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - control unit <-> datapath signal bundle
interface multicycle_control_unit_if #(
  parameter int COUNT_W = 32
);
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               zero;
  logic               mem_ready;
  logic               pc_write;
  logic               ir_write;
  logic               reg_write;
  logic               mem_read;
  logic               mem_write;
  logic               adr_src;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         result_src;
  logic [1:0]         alu_op;
  logic               illegal;
  logic [3:0]         state;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    input  opcode, funct3, zero, mem_ready,
    output pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
           alu_src_a, alu_src_b, result_src, alu_op, illegal, state, instr_count
  );

  modport slave (
    output opcode, funct3, zero, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
           alu_src_a, alu_src_b, result_src, alu_op, illegal, state, instr_count
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - main FSM sequencing fetch/decode/execute/memory/write-back
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input logic                        clk,
  input logic                        rst_n,
  multicycle_control_unit_if.master  bus
);

  state_t             state, next_state;
  logic [COUNT_W-1:0] count;
  logic               retire;
  logic               pc_write_c, ir_write_c, reg_write_c, mem_write_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      count <= '0;
    end else begin
      state <= next_state;
      if (retire) count <= count + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_FETCH:   if (bus.mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        if (bus.opcode == OP_LOAD || bus.opcode == OP_STORE)           next_state = S_MEM_ADR;
        else if (bus.opcode == OP_RTYPE)                               next_state = S_EXEC_R;
        else if (bus.opcode == OP_ITYPE && bus.funct3 == F3_ADDI)      next_state = S_EXEC_I;
        else if (bus.opcode == OP_BRANCH && bus.funct3 == F3_BEQ)      next_state = S_BEQ;
        else                                                           next_state = S_TRAP;
      end
      S_MEM_ADR: next_state = (bus.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  if (bus.mem_ready) next_state = S_MEM_WB;
      S_MEM_WB:  next_state = S_FETCH;
      S_MEM_WR:  if (bus.mem_ready) next_state = S_FETCH;
      S_EXEC_R:  next_state = S_ALU_WB;
      S_EXEC_I:  next_state = S_ALU_WB;
      S_ALU_WB:  next_state = S_FETCH;
      S_BEQ:     next_state = S_FETCH;
      S_TRAP:    next_state = S_TRAP;
      default:   next_state = S_TRAP;
    endcase
  end

  always_comb begin
    pc_write_c     = 1'b0;
    ir_write_c     = 1'b0;
    reg_write_c    = 1'b0;
    mem_write_c    = 1'b0;
    bus.mem_read   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.alu_src_a  = SRC_A_PC;
    bus.alu_src_b  = SRC_B_RS2;
    bus.result_src = RES_ALUOUT;
    bus.alu_op     = ALU_ADD;
    bus.illegal    = 1'b0;
    retire         = 1'b0;
    unique case (state)
      S_FETCH: begin
        bus.mem_read   = 1'b1;
        bus.alu_src_b  = SRC_B_FOUR;
        bus.result_src = RES_ALU;
        ir_write_c     = bus.mem_ready;
        pc_write_c     = bus.mem_ready;
      end
      // branch target is precomputed here so BEQ only needs the compare
      S_DECODE: begin
        bus.alu_src_a = SRC_A_OLDPC;
        bus.alu_src_b = SRC_B_IMM;
      end
      S_MEM_ADR: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        bus.adr_src  = 1'b1;
        bus.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        bus.result_src = RES_MEMDATA;
        reg_write_c    = 1'b1;
        retire         = 1'b1;
      end
      S_MEM_WR: begin
        bus.adr_src = 1'b1;
        mem_write_c = 1'b1;
        retire      = bus.mem_ready;
      end
      S_EXEC_R: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_op    = ALU_RTYPE;
      end
      S_EXEC_I: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_IMM;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        retire      = 1'b1;
      end
      S_BEQ: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_op    = ALU_SUB;
        pc_write_c    = bus.zero;
        retire        = 1'b1;
      end
      S_TRAP:  bus.illegal = 1'b1;
      default: bus.illegal = 1'b1;
    endcase
  end

  // reset holds state at FETCH, so only the architectural writes need masking
  assign bus.pc_write    = pc_write_c  & rst_n;
  assign bus.ir_write    = ir_write_c  & rst_n;
  assign bus.reg_write   = reg_write_c & rst_n;
  assign bus.mem_write   = mem_write_c & rst_n;
  assign bus.state       = state;
  assign bus.instr_count = count;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for the multi-cycle control FSM
module tb_multicycle_control_unit;
  import riscv_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0]  st;
    logic        pcw, irw, rw, mr, mw, adr;
    logic [1:0]  a, b, rs, op;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.COUNT_W(32)) bus ();
  multicycle_control_unit #(.COUNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_count = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t observed();
    exp_t o;
    o.st  = bus.state;
    o.pcw = bus.pc_write;   o.irw = bus.ir_write;  o.rw = bus.reg_write;
    o.mr  = bus.mem_read;   o.mw  = bus.mem_write; o.adr = bus.adr_src;
    o.a   = bus.alu_src_a;  o.b   = bus.alu_src_b; o.rs = bus.result_src;
    o.op  = bus.alu_op;     o.ill = bus.illegal;   o.cnt = bus.instr_count;
    return o;
  endfunction

  function automatic exp_t base(input state_t s);
    exp_t x;
    x     = '0;
    x.st  = s;
    x.cnt = exp_count;
    return x;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      check($sformatf("cycle_st%0d", e.st), 64'(observed()), 64'(e));
    end
  end

  task automatic drv(input logic mr, input logic z, input exp_t x);
    bus.mem_ready = mr;
    bus.zero      = z;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int w);
    exp_t x;
    x = base(S_FETCH); x.mr = 1'b1; x.b = 2'b10; x.rs = 2'b10;
    repeat (w) drv(1'b0, 1'b0, x);
    x.pcw = 1'b1; x.irw = 1'b1;
    drv(1'b1, 1'b0, x);
  endtask

  task automatic decode(input logic [6:0] op, input logic [2:0] f3);
    exp_t x;
    bus.opcode = op; bus.funct3 = f3;
    x = base(S_DECODE); x.a = 2'b01; x.b = 2'b01;
    drv(1'b1, 1'b0, x);
  endtask

  task automatic mem_adr();
    exp_t x;
    x = base(S_MEM_ADR); x.a = 2'b10; x.b = 2'b01;
    drv(1'b1, 1'b0, x);
  endtask

  task automatic do_lw(input int wf, input int wr);
    exp_t x;
    fetch(wf);
    decode(7'b0000011, 3'b010);
    mem_adr();
    x = base(S_MEM_RD); x.adr = 1'b1; x.mr = 1'b1;
    repeat (wr) drv(1'b0, 1'b0, x);
    drv(1'b1, 1'b0, x);
    x = base(S_MEM_WB); x.rs = 2'b01; x.rw = 1'b1;
    drv(1'b0, 1'b0, x);
    exp_count++;
  endtask

  task automatic do_sw(input int ww);
    exp_t x;
    fetch(0);
    decode(7'b0100011, 3'b010);
    mem_adr();
    x = base(S_MEM_WR); x.adr = 1'b1; x.mw = 1'b1;
    repeat (ww) drv(1'b0, 1'b0, x);
    drv(1'b1, 1'b0, x);
    exp_count++;
  endtask

  task automatic do_alu(input logic imm);
    exp_t x;
    fetch(0);
    if (imm) begin
      decode(7'b0010011, 3'b000);
      x = base(S_EXEC_I); x.a = 2'b10; x.b = 2'b01; x.op = 2'b00;
    end else begin
      decode(7'b0110011, 3'b100);
      x = base(S_EXEC_R); x.a = 2'b10; x.b = 2'b00; x.op = 2'b10;
    end
    drv(1'b0, 1'b1, x);
    x = base(S_ALU_WB); x.rw = 1'b1;
    drv(1'b0, 1'b0, x);
    exp_count++;
  endtask

  task automatic do_beq(input logic z);
    exp_t x;
    fetch(0);
    decode(7'b1100011, 3'b000);
    x = base(S_BEQ); x.a = 2'b10; x.op = 2'b01; x.pcw = z;
    drv(1'b0, z, x);
    exp_count++;
  endtask

  task automatic do_trap();
    exp_t x;
    fetch(0);
    decode(7'b1111111, 3'b000);
    x = base(S_TRAP); x.ill = 1'b1;
    for (int i = 0; i < 10; i++) drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), x);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_state"}, 64'(bus.state), 64'(S_FETCH));
    check({tag, "_count"}, 64'(bus.instr_count), 64'd0);
    check({tag, "_wen"}, 64'({bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write}), 64'd0);
    check({tag, "_mem_read"}, 64'(bus.mem_read), 64'd1);
    check({tag, "_illegal"}, 64'(bus.illegal), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.mem_ready = 1'b1; bus.zero = 1'b0; bus.opcode = '0; bus.funct3 = '0;
    @(posedge clk); #1;
    reset_checks("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_lw(0, 0);
    do_sw(2);
    do_alu(1'b0);
    do_alu(1'b1);
    do_beq(1'b1);
    do_beq(1'b0);
    do_lw(1, 2);
    do_trap();

    bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    reset_checks("trap_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_count = '0;
    do_alu(1'b1);
    @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    check("final_count", 64'(bus.instr_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
